// File: rtl/alu_op_sequencer_if.sv
// Bundle for the sequencer: request channel, ALU drive/return lines and response channel.
// slave is the sequencer; master is the datapath control plus the ALU facing it.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    // request channel
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [5:0]       req_funct;
    // ALU drive and return
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_cout;
    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_cout;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_funct,
        input  alu_out, alu_zero, alu_cout,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_funct,
        output alu_out, alu_zero, alu_cout,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issuing side of the ripple ALU: accepts a funct-coded request, drives the ALU from
// registers, waits for the carry chain to settle, then returns the captured result.
module alu_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2    // legal range 1..15
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_e;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    // An illegal funct still spends one cycle in SETTLE so its response arrives one edge late.
    logic             err_pend_q, err_pend_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_err_q, rsp_err_d;

    logic             dec_legal;
    logic [2:0]       dec_op;

    // Decode funct into {sub, op[1:0]}; anything outside the five R-type codes is illegal.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_legal = 1'b1;
        dec_op    = 3'b000;
        unique case (bus.req_funct)
            6'h24:   dec_op = 3'b000;  // AND
            6'h25:   dec_op = 3'b001;  // OR
            6'h20:   dec_op = 3'b010;  // ADD
            6'h22:   dec_op = 3'b110;  // SUB
            6'h2A:   dec_op = 3'b111;  // SLT
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state and next-output logic; everything holds unless a transition says otherwise.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_pend_d   = err_pend_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d = S_SETTLE;
                    if (dec_legal) begin
                        alu_a_d    = bus.req_a;
                        alu_b_d    = bus.req_b;
                        alu_op_d   = dec_op;
                        cnt_d      = SETTLE_LD;
                        err_pend_d = 1'b0;
                    end else begin
                        cnt_d      = 4'd1;
                        err_pend_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = S_RESP;
                    rsp_err_d    = err_pend_q;
                    rsp_result_d = err_pend_q ? '0   : bus.alu_out;
                    rsp_zero_d   = err_pend_q ? 1'b0 : bus.alu_zero;
                    rsp_cout_d   = err_pend_q ? 1'b0 : bus.alu_cout;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake flags are registered decodes of the next state.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand/result registers are ordinary flops, so they are reset like the
        // control state; a reset mid-operation must leave every output at a known value.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            err_pend_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'b000;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_pend_q   <= err_pend_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule
